bp_cce_dir_arbiter: RTL and testbench

//  Shares one CCE directory (I$/D$/A$ segments behind a single port) among num_req_p requesters,
//  e.g. the microcode engine, a directory-init sweeper and a debug port. Selects one request

---
 rtl/bp_cce_pkg.sv | 19 +
 rtl/bp_cce_dir_arb_rr.sv | 33 +++
 rtl/bp_cce_dir_arbiter.sv | 152 +++++++++++++++
 tb/tb_bp_cce_dir_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_cce_pkg.sv
// Shared CCE types: directory arbiter FSM states and sizing helpers.
// Watchdog build option: BP_CCE_DIR_ARB_WDOG_EN.
package bp_cce_pkg;

  typedef enum logic [1:0] {
    e_arb_idle,
    e_arb_send,
    e_arb_wait,
    e_arb_resp
  } bp_cce_dir_arb_state_e;

  // Watchdog counter width: at least 8 bits, wider if the limit needs it.
  function automatic int arb_cnt_w(input int max_v);
    int w;
    w = $clog2(max_v + 1);
    return (w > 8) ? w : 8;
  endfunction

endpackage

// File: rtl/bp_cce_dir_arb_rr.sv
// Combinational round-robin picker: first valid at/after ptr_i, wrapping.
// The pointer register itself lives in the parent.
module bp_cce_dir_arb_rr #(
  parameter int num_req_p = 2,
  localparam int id_w = $clog2(num_req_p)
) (
  input  logic [num_req_p-1:0] v_i,
  input  logic [id_w-1:0]      ptr_i,
  output logic [num_req_p-1:0] grant_oh_o,
  output logic [id_w-1:0]      grant_id_o,
  output logic                 v_o
);

  // Scan from the pointer, wrapping once; take the first valid requester.
  always_comb begin
    int idx;
    grant_oh_o = '0;
    grant_id_o = '0;
    v_o        = 1'b0;
    idx        = 0;
    for (int i = 0; i < num_req_p; i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= num_req_p)
        idx = idx - num_req_p;
      if (!v_o && v_i[idx]) begin
        v_o             = 1'b1;
        grant_id_o      = id_w'(idx);
        grant_oh_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bp_cce_dir_arbiter.sv
// Round-robin arbiter sharing one CCE directory port among requesters.
// Optional read watchdog: define BP_CCE_DIR_ARB_WDOG_EN.
module bp_cce_dir_arbiter
  import bp_cce_pkg::*;
#(
  parameter int num_req_p   = 2,
  parameter int pkt_width_p = 64,
  parameter int wdog_max_p  = 255,
  localparam int id_w = $clog2(num_req_p)
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic [num_req_p-1:0]           req_v_i,
  input  logic [num_req_p-1:0]           req_rd_i,
  input  logic [num_req_p*pkt_width_p-1:0] req_pkt_i,
  output logic [num_req_p-1:0]           req_yumi_o,
  output logic                           dir_r_v_o,
  output logic                           dir_w_v_o,
  output logic [pkt_width_p-1:0]         dir_pkt_o,
  input  logic                           dir_busy_i,
  output logic [num_req_p-1:0]           resp_v_o,
  output logic [id_w-1:0]                owner_o,
  output logic                           busy_o,
  output logic                           err_o
);

  bp_cce_dir_arb_state_e r_state, w_state_n;

  logic [id_w-1:0]        r_ptr;
  logic [id_w-1:0]        r_owner;
  logic                   r_rd;
  logic [pkt_width_p-1:0] r_pkt;

  logic [num_req_p-1:0]   w_grant_oh;
  logic [id_w-1:0]        w_grant_id;
  logic                   w_grant_v;
  logic                   w_accept;
  logic                   w_resp;
  logic                   w_wdog_hit;
  logic [id_w-1:0]        w_ptr_n;
  logic [num_req_p-1:0]   w_owner_oh;

  bp_cce_dir_arb_rr #(
    .num_req_p (num_req_p)
  ) u_rr (
    .v_i        (req_v_i),
    .ptr_i      (r_ptr),
    .grant_oh_o (w_grant_oh),
    .grant_id_o (w_grant_id),
    .v_o        (w_grant_v)
  );

  // Accept only from IDLE with the directory free; reset masks the
  // combinational accept so every output is quiet while held in reset.
  assign w_accept = reset_n_i
                  & (r_state == e_arb_idle)
                  & w_grant_v
                  & ~dir_busy_i;

  assign req_yumi_o = w_accept ? w_grant_oh : '0;

  assign w_ptr_n = (int'(w_grant_id) == num_req_p - 1)
                 ? '0
                 : w_grant_id + id_w'(1);

  assign w_owner_oh = {{(num_req_p-1){1'b0}}, 1'b1} << r_owner;

  assign dir_r_v_o = (r_state == e_arb_send) &  r_rd;
  assign dir_w_v_o = (r_state == e_arb_send) & ~r_rd;

  // Writes complete in SEND; reads complete in RESP.
  assign w_resp   = dir_w_v_o | (r_state == e_arb_resp);
  assign resp_v_o = w_resp ? w_owner_oh : '0;

  assign dir_pkt_o = r_pkt;
  assign owner_o   = r_owner;
  assign busy_o    = (r_state != e_arb_idle);

`ifdef BP_CCE_DIR_ARB_WDOG_EN
  localparam int cnt_w = arb_cnt_w(wdog_max_p);

  logic [cnt_w-1:0] r_wdog_cnt;
  logic             r_err;

  // Fires on the wdog_max_p-th consecutive busy cycle spent in WAIT.
  assign w_wdog_hit = (r_state == e_arb_wait)
                    & dir_busy_i
                    & (r_wdog_cnt == cnt_w'(wdog_max_p - 1));

  // Watchdog count cleared on WAIT entry; error flag is sticky.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wdog_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (r_state == e_arb_send)
        r_wdog_cnt <= '0;
      else if (r_state == e_arb_wait)
        r_wdog_cnt <= r_wdog_cnt + cnt_w'(1);
      if (w_wdog_hit)
        r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  logic w_unused_wdog;

  assign w_unused_wdog = ^wdog_max_p;
  assign w_wdog_hit    = 1'b0;
  assign err_o         = 1'b0;
`endif

  // Next-state: one SEND cycle, reads wait out dir_busy_i.
  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      e_arb_idle: if (w_accept) w_state_n = e_arb_send;
      e_arb_send: w_state_n = r_rd ? e_arb_wait : e_arb_idle;
      e_arb_wait: begin
        if (!dir_busy_i || w_wdog_hit)
          w_state_n = e_arb_resp;
      end
      e_arb_resp: w_state_n = e_arb_idle;
      default:    w_state_n = e_arb_idle;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      r_state <= e_arb_idle;
    else
      r_state <= w_state_n;
  end

  // Latch winner's packet, op type and id; advance fairness pointer.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_ptr   <= '0;
      r_owner <= '0;
      r_rd    <= 1'b0;
      r_pkt   <= '0;
    end else if (w_accept) begin
      r_ptr   <= w_ptr_n;
      r_owner <= w_grant_id;
      r_rd    <= req_rd_i[w_grant_id];
      r_pkt   <= req_pkt_i[w_grant_id*pkt_width_p +: pkt_width_p];
    end
  end

endmodule

// File: tb/tb_bp_cce_dir_arbiter.sv
// Directed bench for bp_cce_dir_arbiter: cycle vector table plus
// hand sequences for fairness, reset mid-op and the watchdog build.
module tb_bp_cce_dir_arbiter;

  localparam logic [63:0] P0 = 64'hA0A0_0000_1111_0000;
  localparam logic [63:0] P1 = 64'hB1B1_2222_0000_3333;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [1:0]   req_v;
  logic [1:0]   req_rd;
  logic [127:0] req_pkt;
  logic [1:0]   yumi;
  logic         dir_r_v;
  logic         dir_w_v;
  logic [63:0]  dir_pkt;
  logic         dir_busy;
  logic [1:0]   resp_v;
  logic         owner;
  logic         busy;
  logic         err;

  always #5 clk = ~clk;

  assign req_pkt = {P1, P0};

  bp_cce_dir_arbiter #(
    .num_req_p   (2),
    .pkt_width_p (64),
    .wdog_max_p  (8)
  ) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .req_v_i    (req_v),
    .req_rd_i   (req_rd),
    .req_pkt_i  (req_pkt),
    .req_yumi_o (yumi),
    .dir_r_v_o  (dir_r_v),
    .dir_w_v_o  (dir_w_v),
    .dir_pkt_o  (dir_pkt),
    .dir_busy_i (dir_busy),
    .resp_v_o   (resp_v),
    .owner_o    (owner),
    .busy_o     (busy),
    .err_o      (err)
  );

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  rd;
    logic        bz;
    logic [1:0]  yumi;
    logic        rv;
    logic        wv;
    logic [1:0]  resp;
    logic        bsy;
    logic        own;
    logic [63:0] pkt;
  } vec_t;

  vec_t vt[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [1:0] v, input logic [1:0] rd, input logic bz,
    input logic [1:0] y, input logic rv, input logic wv,
    input logic [1:0] rs, input logic bsy, input logic own,
    input logic [63:0] pkt);
    vec_t x;
    x.v = v; x.rd = rd; x.bz = bz;
    x.yumi = y; x.rv = rv; x.wv = wv;
    x.resp = rs; x.bsy = bsy; x.own = own; x.pkt = pkt;
    return x;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, " yumi"},  64'(yumi),    64'd0);
    chk({tag, " rv"},    64'(dir_r_v), 64'd0);
    chk({tag, " wv"},    64'(dir_w_v), 64'd0);
    chk({tag, " resp"},  64'(resp_v),  64'd0);
    chk({tag, " busy"},  64'(busy),    64'd0);
    chk({tag, " owner"}, 64'(owner),   64'd0);
    chk({tag, " pkt"},   dir_pkt,      64'd0);
    chk({tag, " err"},   64'(err),     64'd0);
  endtask

  initial begin
    int g0, g1;
    reset_n  = 1'b0;
    req_v    = '0;
    req_rd   = '0;
    dir_busy = 1'b0;

    // Cycle table: single write, read with busy, gate, alternation.
    vt.push_back(mk(2'b01,2'b00,0, 2'b01,0,0,2'b00,0,0,64'd0));
    vt.push_back(mk(2'b00,2'b00,0, 2'b00,0,1,2'b01,1,0,P0));
    vt.push_back(mk(2'b00,2'b00,0, 2'b00,0,0,2'b00,0,0,P0));
    vt.push_back(mk(2'b10,2'b10,0, 2'b10,0,0,2'b00,0,0,P0));
    vt.push_back(mk(2'b00,2'b00,0, 2'b00,1,0,2'b00,1,1,P1));
    for (int i = 0; i < 4; i++)
      vt.push_back(mk(2'b01,2'b00,1, 2'b00,0,0,2'b00,1,1,P1));
    vt.push_back(mk(2'b01,2'b00,0, 2'b00,0,0,2'b00,1,1,P1));
    vt.push_back(mk(2'b01,2'b00,0, 2'b00,0,0,2'b10,1,1,P1));
    vt.push_back(mk(2'b01,2'b00,0, 2'b01,0,0,2'b00,0,1,P1));
    vt.push_back(mk(2'b00,2'b00,0, 2'b00,0,1,2'b01,1,0,P0));
    vt.push_back(mk(2'b01,2'b00,1, 2'b00,0,0,2'b00,0,0,P0));
    vt.push_back(mk(2'b01,2'b00,1, 2'b00,0,0,2'b00,0,0,P0));
    vt.push_back(mk(2'b01,2'b00,0, 2'b01,0,0,2'b00,0,0,P0));
    vt.push_back(mk(2'b00,2'b00,0, 2'b00,0,1,2'b01,1,0,P0));
    vt.push_back(mk(2'b11,2'b00,0, 2'b10,0,0,2'b00,0,0,P0));
    vt.push_back(mk(2'b11,2'b00,0, 2'b00,0,1,2'b10,1,1,P1));
    vt.push_back(mk(2'b11,2'b00,0, 2'b01,0,0,2'b00,0,1,P1));
    vt.push_back(mk(2'b11,2'b00,0, 2'b00,0,1,2'b01,1,0,P0));

    repeat (2) @(negedge clk);
    req_v = 2'b11;
    #1;
    chk_all_zero("por");
    req_v = '0;
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vt[k]) begin
      req_v    = vt[k].v;
      req_rd   = vt[k].rd;
      dir_busy = vt[k].bz;
      #1;
      chk($sformatf("v%0d yumi", k),  64'(yumi),    64'(vt[k].yumi));
      chk($sformatf("v%0d rv", k),    64'(dir_r_v), 64'(vt[k].rv));
      chk($sformatf("v%0d wv", k),    64'(dir_w_v), 64'(vt[k].wv));
      chk($sformatf("v%0d resp", k),  64'(resp_v),  64'(vt[k].resp));
      chk($sformatf("v%0d busy", k),  64'(busy),    64'(vt[k].bsy));
      chk($sformatf("v%0d owner", k), 64'(owner),   64'(vt[k].own));
      chk($sformatf("v%0d pkt", k),   dir_pkt,      vt[k].pkt);
      chk($sformatf("v%0d err", k),   64'(err),     64'd0);
      @(negedge clk);
    end

    // Fairness: both held, writes; pointer sits at 1 here.
    g0 = 0;
    g1 = 0;
    req_v    = 2'b11;
    req_rd   = 2'b00;
    dir_busy = 1'b0;
    for (int op = 0; op < 100; op++) begin
      logic [1:0] ex;
      ex = (op % 2 == 0) ? 2'b10 : 2'b01;
      #1;
      chk($sformatf("fair%0d yumi", op), 64'(yumi), 64'(ex));
      if (yumi == 2'b01) g0++;
      if (yumi == 2'b10) g1++;
      @(negedge clk);
      #1;
      chk($sformatf("fair%0d resp", op), 64'(resp_v), 64'(ex));
      @(negedge clk);
    end
    chk("fair g0", 64'(g0), 64'd50);
    chk("fair g1", 64'(g1), 64'd50);
    req_v = '0;
    @(negedge clk);

    // Reset in the middle of a read WAIT; pointer is 1 before it.
    req_v  = 2'b01;
    req_rd = 2'b01;
    #1;
    chk("rst acc", 64'(yumi), 64'(2'b01));
    @(negedge clk);
    req_v    = '0;
    dir_busy = 1'b1;
    #1;
    chk("rst send", 64'(dir_r_v), 64'd1);
    @(negedge clk);
    #1;
    chk("rst wait", 64'(busy), 64'd1);
    @(negedge clk);
    req_v   = 2'b01;
    reset_n = 1'b0;
    #1;
    chk_all_zero("rstmid");
    @(negedge clk);
    req_v    = '0;
    dir_busy = 1'b0;
    reset_n  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("rst%0d resp", i), 64'(resp_v), 64'd0);
      chk($sformatf("rst%0d busy", i), 64'(busy), 64'd0);
      @(negedge clk);
    end
    req_v  = 2'b11;
    req_rd = 2'b00;
    #1;
    chk("rst ptr0", 64'(yumi), 64'(2'b01));
    @(negedge clk);
    req_v = '0;
    #1;
    chk("rst wr resp", 64'(resp_v), 64'(2'b01));
    @(negedge clk);

`ifdef BP_CCE_DIR_ARB_WDOG_EN
    // Watchdog: busy stuck high through WAIT.
    req_v  = 2'b01;
    req_rd = 2'b01;
    #1;
    chk("wd acc", 64'(yumi), 64'(2'b01));
    @(negedge clk);
    req_v    = '0;
    dir_busy = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 8; i++) begin
      #1;
      chk($sformatf("wd w%0d err", i),  64'(err),    64'd0);
      chk($sformatf("wd w%0d resp", i), 64'(resp_v), 64'd0);
      chk($sformatf("wd w%0d busy", i), 64'(busy),   64'd1);
      @(negedge clk);
    end
    #1;
    chk("wd resp", 64'(resp_v), 64'(2'b01));
    chk("wd err",  64'(err),    64'd1);
    @(negedge clk);
    dir_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("wd sticky%0d", i), 64'(err), 64'd1);
      chk($sformatf("wd idle%0d", i), 64'(busy), 64'd0);
      @(negedge clk);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
